// File: rtl/fetch_mem_unit.sv
// Program counter, instruction fetch and data-memory access unit for the multicycle core.
// Runs one command at a time and waits on mem_ready, with an optional watchdog that aborts stuck accesses.
module fetch_mem_unit #(
    parameter int unsigned DATA_W     = 16,
    parameter int unsigned ADDR_W     = 9,
    parameter int unsigned RESET_PC   = 0,
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              cmd_valid,
    input  logic [2:0]        cmd,
    output logic              cmd_ready,
    input  logic [7:0]        branch_off,
    input  logic [ADDR_W-1:0] jump_target,
    input  logic [ADDR_W-1:0] data_addr_in,
    input  logic [DATA_W-1:0] store_data,
    output logic [1:0]        mem_cmd,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    input  logic              mem_ready,
    output logic [ADDR_W-1:0] pc,
    output logic [DATA_W-1:0] ir,
    output logic [DATA_W-1:0] load_data,
    output logic              done,
    output logic              busy,
    output logic              halt,
    output logic              err
);

    localparam int unsigned WCNT_W = (WAIT_LIMIT < 2) ? 1 : $clog2(WAIT_LIMIT + 1);

    localparam logic [2:0] CMD_NOP    = 3'b000;
    localparam logic [2:0] CMD_FETCH  = 3'b001;
    localparam logic [2:0] CMD_LOAD   = 3'b010;
    localparam logic [2:0] CMD_STORE  = 3'b011;
    localparam logic [2:0] CMD_PC_INC = 3'b100;
    localparam logic [2:0] CMD_BRANCH = 3'b101;
    localparam logic [2:0] CMD_JUMP   = 3'b110;
    localparam logic [2:0] CMD_HALT   = 3'b111;

    localparam logic [1:0] MEM_NONE  = 2'b00;
    localparam logic [1:0] MEM_READ  = 2'b01;
    localparam logic [1:0] MEM_WRITE = 2'b10;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_FETCH = 3'd1,
        S_LOAD  = 3'd2,
        S_STORE = 3'd3,
        S_HALT  = 3'd4,
        S_ERR   = 3'd5
    } state_e;

    state_e              state_q;
    logic [ADDR_W-1:0]   pc_q;
    logic [ADDR_W-1:0]   pc_d;
    logic [ADDR_W-1:0]   daddr_q;
    logic [DATA_W-1:0]   ir_q;
    logic [DATA_W-1:0]   load_q;
    logic [DATA_W-1:0]   wdata_q;
    logic                done_q;
    logic [WCNT_W-1:0]   wait_q;

    // Next PC for the PC-update commands; the offset is sign-extended to the PC width.
    always_comb begin
        pc_d = pc_q;
        case (cmd)
            CMD_PC_INC: pc_d = pc_q + ADDR_W'(1);
            CMD_BRANCH: pc_d = pc_q + ADDR_W'(1) + ADDR_W'($signed(branch_off));
            CMD_JUMP:   pc_d = jump_target;
            default:    pc_d = pc_q;
        endcase
    end

    // Control FSM with all architectural registers.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= S_IDLE;
            pc_q    <= ADDR_W'(RESET_PC);
            daddr_q <= '0;
            ir_q    <= '0;
            load_q  <= '0;
            wdata_q <= '0;
            done_q  <= 1'b0;
            wait_q  <= '0;
        end else begin
            done_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (cmd_valid) begin
                        case (cmd)
                            CMD_FETCH: state_q <= S_FETCH;
                            CMD_LOAD: begin
                                daddr_q <= data_addr_in;
                                state_q <= S_LOAD;
                            end
                            CMD_STORE: begin
                                daddr_q <= data_addr_in;
                                wdata_q <= store_data;
                                state_q <= S_STORE;
                            end
                            CMD_PC_INC, CMD_BRANCH, CMD_JUMP: begin
                                pc_q   <= pc_d;
                                done_q <= 1'b1;
                            end
                            CMD_NOP:  done_q  <= 1'b1;
                            CMD_HALT: state_q <= S_HALT;
                            default:  state_q <= S_IDLE;
                        endcase
                    end
                end
                S_FETCH, S_LOAD, S_STORE: begin
                    // Completion takes priority over the watchdog on the same edge.
                    if (mem_ready) begin
                        if (state_q == S_FETCH) begin
                            ir_q <= mem_rdata;
                        end else if (state_q == S_LOAD) begin
                            load_q <= mem_rdata;
                        end
                        state_q <= S_IDLE;
                        done_q  <= 1'b1;
                        wait_q  <= '0;
                    end else if ((WAIT_LIMIT != 0) && (wait_q == WCNT_W'(WAIT_LIMIT))) begin
                        state_q <= S_ERR;
                        wait_q  <= '0;
                    end else if (wait_q != {WCNT_W{1'b1}}) begin
                        wait_q <= wait_q + WCNT_W'(1);
                    end
                end
                S_HALT:  state_q <= S_HALT;
                S_ERR:   state_q <= S_ERR;
                default: state_q <= S_IDLE;
            endcase
        end
    end

    // Memory bus and status decode purely from the registered state.
    always_comb begin
        mem_cmd  = MEM_NONE;
        mem_addr = pc_q;
        busy     = 1'b0;
        case (state_q)
            S_FETCH: begin
                mem_cmd = MEM_READ;
                busy    = 1'b1;
            end
            S_LOAD: begin
                mem_cmd  = MEM_READ;
                mem_addr = daddr_q;
                busy     = 1'b1;
            end
            S_STORE: begin
                mem_cmd  = MEM_WRITE;
                mem_addr = daddr_q;
                busy     = 1'b1;
            end
            default: begin
                mem_cmd  = MEM_NONE;
                mem_addr = pc_q;
                busy     = 1'b0;
            end
        endcase
    end

    assign cmd_ready = (state_q == S_IDLE);
    assign halt      = (state_q == S_HALT);
    assign err       = (state_q == S_ERR);
    assign mem_wdata = wdata_q;
    assign pc        = pc_q;
    assign ir        = ir_q;
    assign load_data = load_q;
    assign done      = done_q;

endmodule
